// File: rtl/clk_enable_sched.sv
// Clock-enable scheduler: turns in_clk into a one-cycle cpu_en pulse stream
// (halt / free-run divider / single-step / fixed-length burst).
module clk_enable_sched #(
    parameter int CNT_W       = 18,
    parameter int DEFAULT_DIV = 208333,
    parameter int SYNC_STAGES = 2
) (
    input  logic             in_clk,
    input  logic             reset_clk,
    input  logic [1:0]       mode,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_data,
    output logic             div_ack,
    input  logic             step_btn,
    input  logic [7:0]       burst_len,
    output logic             cpu_en,
    output logic             busy,
    output logic [CNT_W-1:0] div_cur
);

    // state       | meaning
    // S_HALT      | no pulses, counter held at 0
    // S_RUN       | free-running divider, one pulse per div_cur cycles
    // S_STEP_IDLE | one pulse per step request, divider bypassed
    // S_BURST_IDLE| waiting for a step request to start a burst
    // S_BURST_ACT | divider running, rem pulses still to issue
    typedef enum logic [2:0] {
        S_HALT, S_RUN, S_STEP_IDLE, S_BURST_IDLE, S_BURST_ACT
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t                 state;
    logic [1:0]             mode_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       pend_val;
    logic                   pend;
    logic [7:0]             rem;
    logic [SYNC_STAGES-1:0] sync;
    logic                   step_prev;
    logic                   step_req;

    logic                   mode_chg;
    logic                   running;
    logic                   at_term;
    logic                   wrap;
    logic                   apply;
    logic [CNT_W-1:0]       div_clamped;

    function automatic state_t mode_state(input logic [1:0] m);
        case (m)
            2'b01:   return S_RUN;
            2'b10:   return S_STEP_IDLE;
            2'b11:   return S_BURST_IDLE;
            default: return S_HALT;
        endcase
    endfunction

    always_comb begin
        mode_chg    = (mode != mode_q);
        running     = (state == S_RUN) || (state == S_BURST_ACT);
        at_term     = (cnt == div_cur - ONE);
        wrap        = !mode_chg && running && at_term;
        // A running divider only takes a new period on its wrap edge.
        apply       = pend && (running ? wrap : 1'b1);
        div_clamped = (div_data == '0) ? ONE : div_data;
    end

    always_ff @(posedge in_clk or posedge reset_clk) begin
        if (reset_clk) begin
            state     <= S_HALT;
            mode_q    <= 2'b00;
            cnt       <= '0;
            pend_val  <= '0;
            pend      <= 1'b0;
            rem       <= '0;
            sync      <= '0;
            step_prev <= 1'b0;
            step_req  <= 1'b0;
            cpu_en    <= 1'b0;
            div_ack   <= 1'b0;
            busy      <= 1'b0;
            div_cur   <= CNT_W'(DEFAULT_DIV);
        end else begin
            mode_q    <= mode;
            sync      <= {sync[SYNC_STAGES-2:0], step_btn};
            step_prev <= sync[SYNC_STAGES-1];
            step_req  <= sync[SYNC_STAGES-1] & ~step_prev;

            div_ack <= apply;
            if (apply)
                div_cur <= pend_val;
            if (div_wr) begin
                pend     <= 1'b1;
                pend_val <= div_clamped;
            end else if (apply) begin
                pend <= 1'b0;
            end

            cpu_en <= 1'b0;
            if (mode_chg) begin
                cnt   <= '0;
                busy  <= 1'b0;
                state <= mode_state(mode);
            end else begin
                case (state)
                    S_RUN: begin
                        if (at_term) begin
                            cnt    <= '0;
                            cpu_en <= 1'b1;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    S_BURST_ACT: begin
                        if (at_term) begin
                            cnt    <= '0;
                            cpu_en <= 1'b1;
                            rem    <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                busy  <= 1'b0;
                                state <= S_BURST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    S_STEP_IDLE: begin
                        cnt    <= '0;
                        cpu_en <= step_req;
                    end
                    S_BURST_IDLE: begin
                        cnt <= '0;
                        if (step_req && burst_len != 8'd0) begin
                            rem   <= burst_len;
                            busy  <= 1'b1;
                            state <= S_BURST_ACT;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_sched.sv
// Directed bench for clk_enable_sched with a short default divisor of 4.
module tb_clk_enable_sched;

    localparam int CNT_W = 18;

    logic             in_clk;
    logic             reset_clk;
    logic [1:0]       mode;
    logic             div_wr;
    logic [CNT_W-1:0] div_data;
    logic             div_ack;
    logic             step_btn;
    logic [7:0]       burst_len;
    logic             cpu_en;
    logic             busy;
    logic [CNT_W-1:0] div_cur;

    int n_checks = 0;
    int n_fail   = 0;

    clk_enable_sched #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(4),
        .SYNC_STAGES(2)
    ) dut (
        .in_clk   (in_clk),
        .reset_clk(reset_clk),
        .mode     (mode),
        .div_wr   (div_wr),
        .div_data (div_data),
        .div_ack  (div_ack),
        .step_btn (step_btn),
        .burst_len(burst_len),
        .cpu_en   (cpu_en),
        .busy     (busy),
        .div_cur  (div_cur)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    initial begin
        reset_clk = 1'b1;
        mode      = 2'b01;
        div_wr    = 1'b0;
        div_data  = '0;
        step_btn  = 1'b0;
        burst_len = 8'd0;
        repeat (2) @(posedge in_clk);
        #1;
        check("rst_en", cpu_en, 0);
        check("rst_ack", div_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_div", div_cur, 4);
        reset_clk = 1'b0;

        // RUN at divisor 4: first pulse 4 cycles after the first edge
        for (int i = 1; i <= 13; i++) begin
            tick();
            check("run_en", cpu_en, (i > 1 && (i - 1) % 4 == 0));
            check("run_busy", busy, 0);
        end
        check("run_div", div_cur, 4);

        // divisor 2 written mid-period, takes effect at the wrap
        tick();
        check("wr_pre_en", cpu_en, 0);
        div_wr = 1'b1; div_data = 18'd2;
        tick();
        div_wr = 1'b0;
        check("wr_a_en", cpu_en, 0);
        check("wr_a_ack", div_ack, 0);
        tick();
        check("wr_b_en", cpu_en, 0);
        check("wr_b_ack", div_ack, 0);
        check("wr_b_div", div_cur, 4);
        tick();
        check("wr_c_en", cpu_en, 1);
        check("wr_c_ack", div_ack, 1);
        check("wr_c_div", div_cur, 2);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("div2_en", cpu_en, (i % 2 == 0));
            check("div2_ack", div_ack, 0);
        end

        // divisor 0 clamps to 1: continuous enable
        div_wr = 1'b1; div_data = 18'd0;
        tick();
        div_wr = 1'b0;
        check("wr0_a_en", cpu_en, 0);
        check("wr0_a_ack", div_ack, 0);
        tick();
        check("wr0_b_en", cpu_en, 1);
        check("wr0_b_ack", div_ack, 1);
        check("wr0_b_div", div_cur, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("div1_en", cpu_en, 1);
            check("div1_ack", div_ack, 0);
        end

        // single-step: held button gives exactly one pulse, 4 cycles after the rise
        mode = 2'b10;
        tick();
        check("step_chg_en", cpu_en, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("step_idle_en", cpu_en, 0);
        end
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("step1_en", cpu_en, (i == 4));
        end
        step_btn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("step_rel_en", cpu_en, 0);
        end
        step_btn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("step2_en", cpu_en, (i == 4));
        end
        step_btn = 1'b0;
        repeat (3) tick();

        // divisor change outside a running divider applies on the next edge
        div_wr = 1'b1; div_data = 18'd2;
        tick();
        div_wr = 1'b0;
        check("idle_wr_a_ack", div_ack, 0);
        tick();
        check("idle_wr_b_ack", div_ack, 1);
        check("idle_wr_b_div", div_cur, 2);
        tick();
        check("idle_wr_c_ack", div_ack, 0);

        // burst of 3 at divisor 2
        mode = 2'b11; burst_len = 8'd3;
        repeat (3) tick();
        check("burst_idle_busy", busy, 0);
        step_btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("burst3_busy", busy, (i >= 4 && i <= 9));
            check("burst3_en", cpu_en, (i == 6 || i == 8 || i == 10));
        end
        step_btn = 1'b0;
        repeat (3) tick();

        // zero-length burst is ignored
        burst_len = 8'd0;
        step_btn  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("burst0_busy", busy, 0);
            check("burst0_en", cpu_en, 0);
        end
        step_btn = 1'b0;
        repeat (3) tick();

        // burst of 5 aborted by a mode change after two pulses
        burst_len = 8'd5;
        step_btn  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("burst5_en", cpu_en, (i == 6 || i == 8));
            check("burst5_busy", busy, (i >= 4));
        end
        mode = 2'b00; step_btn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("abort_busy", busy, 0);
            check("abort_en", cpu_en, 0);
            check("abort_cnt", dut.cnt, 0);
        end
        mode = 2'b11;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("reburst_busy", busy, 0);
            check("reburst_en", cpu_en, 0);
        end

        // reset mid-RUN with a divisor write still pending
        mode = 2'b01;
        tick();
        check("pre_rst_a_en", cpu_en, 0);
        tick();
        check("pre_rst_b_en", cpu_en, 0);
        div_wr = 1'b1; div_data = 18'd7;
        tick();
        div_wr = 1'b0;
        check("pre_rst_c_en", cpu_en, 1);
        check("pre_rst_c_ack", div_ack, 0);
        #2 reset_clk = 1'b1;
        #1;
        check("async_rst_en", cpu_en, 0);
        check("async_rst_ack", div_ack, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_div", div_cur, 4);
        repeat (2) @(posedge in_clk);
        #1 reset_clk = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("post_rst_en", cpu_en, (i == 5 || i == 9));
            check("post_rst_ack", div_ack, 0);
            check("post_rst_div", div_cur, 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_enable_sched.md
Name: clk_enable_sched

Overview:
- Single-clock scheduler that produces a one-cycle clock-enable pulse (cpu_en) for the multi-cycle processor, replacing a free-running divided clock.
- Selects between halt, free-run at a programmable divide ratio, single-step on a push-button, and fixed-length burst modes.
- Divide ratio is reconfigurable at runtime through a write/acknowledge handshake that is applied only on a pulse boundary.

Parameters:
CNT_W, 18, width of divide counter and divisor registers
DEFAULT_DIV, 208333, divisor loaded at reset (in_clk cycles per cpu_en pulse)
SYNC_STAGES, 2, flip-flop stages synchronising step_btn

Ports:
in_clk  input  1  system clock (100 MHz board clock)
reset_clk  input  1  asynchronous reset, active-high
mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
div_wr  input  1  one-cycle strobe: load div_data into pending divisor
div_data  input  CNT_W  new divisor value
div_ack  output  1  one-cycle pulse when pending divisor becomes active
step_btn  input  1  asynchronous push-button, already debounced
burst_len  input  8  pulses per burst, sampled at burst start
cpu_en  output  1  one-cycle enable pulse to processor
busy  output  1  high while a burst is in progress
div_cur  output  CNT_W  currently active divisor

Behaviour:
- Reset (asynchronous, active-high): cpu_en=0, div_ack=0, busy=0, div_cur=DEFAULT_DIV, counter=0, pending flag=0, synchroniser and edge registers=0, FSM=HALT.
- Divisor clamp: div_data of 0 is stored as 1. Divisor 1 gives cpu_en high every cycle in RUN.
- Divide counter:
  - Counts 0..div_cur-1 while in RUN, or in BURST with busy=1; otherwise it is held at 0.
  - cpu_en is a registered output. It is high in the cycle after the counter reaches div_cur-1, and the counter wraps to 0 on that same edge.
  - Consequence: in RUN, cpu_en pulses exactly once every div_cur cycles. The first pulse rises div_cur cycles after the first edge that samples mode=01.
- Mode changes:
  - Any change of the mode input is detected by a registered compare.
  - On a change, the counter clears to 0, any burst is aborted (busy drops next cycle), and no cpu_en pulse is issued on that edge.
- FSM states:
  - HALT: no pulses.
  - RUN: free-running pulses as above.
  - STEP_IDLE: waits for a step request; no pulses.
  - BURST_IDLE: waits for a step request; no pulses.
  - BURST_ACT: counter runs; remaining count decrements on each pulse. When the remaining count reaches 0, go to BURST_IDLE and drop busy in the same edge that issues the last pulse.
- Transitions:
  - mode 00 leads to HALT; mode 01 leads to RUN; mode 10 leads to STEP_IDLE; mode 11 leads to BURST_IDLE.
  - In BURST_IDLE, a step request loads the remaining count from burst_len and enters BURST_ACT.
- Step request:
  - Produced by rising-edge detection after SYNC_STAGES synchroniser flops.
  - A step_btn rise is seen as a request 3 cycles later (SYNC_STAGES=2).
  - In STEP_IDLE, a request makes cpu_en high for exactly one cycle on the following edge (button-to-pulse latency 4 cycles). It does not wait for the divider.
  - Holding step_btn high gives one pulse only.
  - Requests in HALT and RUN are ignored. Requests in BURST_ACT are ignored; there is no re-trigger.
  - burst_len=0: request is ignored and busy stays 0.
- Divisor handshake:
  - div_wr loads the pending register and sets the pending flag.
  - Application while the counter is running (RUN, BURST_ACT): pending is applied on the edge where the counter wraps, so the next period uses the new value.
  - Application in any other state: pending is applied on the next edge.
  - div_ack pulses high for one cycle in the cycle after application, together with the updated div_cur.
  - A second div_wr before application overwrites the pending value, and only one div_ack is produced.
  - div_wr on the same edge as an application: the old pending value is applied and acknowledged, and the new value stays pending.
- Reset mid-operation: all state returns to reset values immediately, including a pending divisor, which is discarded without ack.

Test Plan:
- DEFAULT_DIV=4, release reset with mode=01 -> cpu_en high at cycles 4, 8, 12 after first edge; div_cur=4; busy=0.
- RUN with div_cur=4, write div_data=2 mid-period -> period completes at 4, div_ack single pulse with div_cur=2, subsequent pulses every 2 cycles; div_data=0 -> div_cur=1, cpu_en continuously high.
- mode=10, step_btn held high 20 cycles -> exactly one cpu_en pulse, 4 cycles after the rise; second press gives one more pulse.
- mode=11, burst_len=3, div_cur=2, press step_btn -> busy=1, three pulses 2 cycles apart, busy=0 with last pulse; burst_len=0 press -> no pulse, busy stays 0.
- During burst (2 of 5 pulses done) switch mode to 00 -> busy=0 next cycle, no further pulses, counter 0; return to 11 without press -> no pulses.
- Assert reset_clk mid-RUN with a div_wr pending -> outputs zero asynchronously, div_cur=DEFAULT_DIV, no div_ack after release.
